// File: rtl/rat_int_ctrl.sv
// Interrupt controller: edge-detected sources, mask register, global enable,
// and a request/service handshake with the control unit.
module rat_int_ctrl #(
    parameter logic [7:0] MASK_PORT = 8'h30,
    parameter int         NSRC      = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [NSRC-1:0]         INT_IN,
    input  logic                    I_SET,
    input  logic                    I_CLR,
    input  logic                    INT_ACK,
    input  logic                    RETI,
    input  logic                    IO_STRB,
    input  logic [7:0]              PORT_ID,
    input  logic [7:0]              OUT_PORT,
    output logic                    INTV,
    output logic [$clog2(NSRC)-1:0] INT_ID,
    output logic                    I_FLAG,
    output logic [NSRC-1:0]         MASK,
    output logic [NSRC-1:0]         PENDING
);

    localparam int IDW = $clog2(NSRC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t          r_state;
    logic            r_intv;
    logic [IDW-1:0]  r_int_id;
    logic            r_iflag;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_prev;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_clr;
    logic [IDW-1:0]  w_win;
    logic            w_req;
    logic            w_ack;
    logic            w_mask_wr;
    logic            w_unused_out;

    assign w_edge       = r_sync2 & ~r_prev;
    assign w_elig       = r_pending & r_mask;
    assign w_req        = r_iflag & (|w_elig);
    assign w_ack        = (r_state == S_REQ) & INT_ACK;
    assign w_mask_wr    = IO_STRB & (PORT_ID == MASK_PORT);
    assign w_unused_out = &{1'b0, OUT_PORT[7:NSRC]};

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        w_win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = IDW'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_ack) w_clr[r_int_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= INT_IN;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_mask <= '0;
        end else if (w_mask_wr) begin
            r_mask <= OUT_PORT[NSRC-1:0];
        end
    end

    // A fresh edge takes precedence over the acknowledge clear.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_intv   <= 1'b0;
            r_int_id <= '0;
            r_iflag  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (I_CLR)      r_iflag <= 1'b0;
                    else if (I_SET) r_iflag <= 1'b1;
                    if (w_req) begin
                        r_state  <= S_REQ;
                        r_intv   <= 1'b1;
                        r_int_id <= w_win;
                    end
                end
                S_REQ: begin
                    if (INT_ACK) begin
                        r_state <= S_SERVICE;
                        r_intv  <= 1'b0;
                        r_iflag <= 1'b0;
                    end else begin
                        if (I_CLR)      r_iflag <= 1'b0;
                        else if (I_SET) r_iflag <= 1'b1;
                        if (!w_req) begin
                            r_state <= S_IDLE;
                            r_intv  <= 1'b0;
                        end
                    end
                end
                S_SERVICE: begin
                    if (RETI) begin
                        r_state <= S_IDLE;
                        r_iflag <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_intv  <= 1'b0;
                end
            endcase
        end
    end

    assign INTV    = r_intv;
    assign INT_ID  = r_int_id;
    assign I_FLAG  = r_iflag;
    assign MASK    = r_mask;
    assign PENDING = r_pending;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed self-checking bench for rat_int_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rat_int_ctrl;

    logic       clk;
    logic       RESET;
    logic [3:0] INT_IN;
    logic       I_SET;
    logic       I_CLR;
    logic       INT_ACK;
    logic       RETI;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       INTV;
    logic [1:0] INT_ID;
    logic       I_FLAG;
    logic [3:0] MASK;
    logic [3:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    rat_int_ctrl #(.MASK_PORT(8'h30), .NSRC(4)) dut (
        .clk      (clk),
        .RESET    (RESET),
        .INT_IN   (INT_IN),
        .I_SET    (I_SET),
        .I_CLR    (I_CLR),
        .INT_ACK  (INT_ACK),
        .RETI     (RETI),
        .IO_STRB  (IO_STRB),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .INTV     (INTV),
        .INT_ID   (INT_ID),
        .I_FLAG   (I_FLAG),
        .MASK     (MASK),
        .PENDING  (PENDING)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        IO_STRB  = 1'b1;
        PORT_ID  = 8'h30;
        OUT_PORT = {4'hA, m};
        tick();
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic pulse_set();
        I_SET = 1'b1; tick(); I_SET = 1'b0;
    endtask

    task automatic pulse_clr();
        I_CLR = 1'b1; tick(); I_CLR = 1'b0;
    endtask

    task automatic pulse_ack();
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    endtask

    task automatic pulse_reti();
        RETI = 1'b1; tick(); RETI = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(2);
        n_checks++;
        if ({INTV, INT_ID, I_FLAG, MASK, PENDING} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 000",
                     {INTV, INT_ID, I_FLAG, MASK, PENDING});
        end
        #2 RESET = 1'b0;
        tick(2);
        n_checks++;
        if ({INTV, I_FLAG, MASK, PENDING} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_release: got %h want 000",
                     {INTV, I_FLAG, MASK, PENDING});
        end
    endtask

    task automatic test_basic();
        write_mask(4'hF);
        n_checks++;
        if (MASK !== 4'hF) begin
            n_fail++; $display("FAIL basic_mask: got %h want f", MASK);
        end
        pulse_set();
        n_checks++;
        if (I_FLAG !== 1'b1) begin
            n_fail++; $display("FAIL basic_iset: got %b want 1", I_FLAG);
        end
        INT_IN = 4'b0100;
        tick(2);
        n_checks++;
        if (PENDING !== 4'b0000) begin
            n_fail++; $display("FAIL basic_pend_n1: got %b want 0000", PENDING);
        end
        tick();
        n_checks++;
        if (PENDING !== 4'b0100 || INTV !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pend_n2: got pend=%b intv=%b want 0100/0",
                     PENDING, INTV);
        end
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd2) begin
            n_fail++;
            $display("FAIL basic_req: got intv=%b id=%0d want 1/2", INTV, INT_ID);
        end
        INT_IN = 4'b0000;
        pulse_ack();
        n_checks++;
        if ({INTV, I_FLAG, PENDING} !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL basic_ack: got intv=%b iflag=%b pend=%b want 0/0/0000",
                     INTV, I_FLAG, PENDING);
        end
        pulse_reti();
        n_checks++;
        if (I_FLAG !== 1'b1 || INTV !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_reti: got iflag=%b intv=%b want 1/0", I_FLAG, INTV);
        end
        tick(2);
    endtask

    task automatic test_priority();
        INT_IN = 4'b1010;
        tick(4);
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd1 || PENDING !== 4'b1010) begin
            n_fail++;
            $display("FAIL prio_first: got intv=%b id=%0d pend=%b want 1/1/1010",
                     INTV, INT_ID, PENDING);
        end
        INT_IN = 4'b0000;
        pulse_ack();
        tick(2);
        n_checks++;
        if (INTV !== 1'b0 || PENDING !== 4'b1000 || INT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL prio_service: got intv=%b pend=%b id=%0d want 0/1000/1",
                     INTV, PENDING, INT_ID);
        end
        pulse_reti();
        n_checks++;
        if (INTV !== 1'b0 || I_FLAG !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_reti: got intv=%b iflag=%b want 0/1", INTV, I_FLAG);
        end
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd3) begin
            n_fail++;
            $display("FAIL prio_second: got intv=%b id=%0d want 1/3", INTV, INT_ID);
        end
        pulse_ack();
        pulse_reti();
        tick();
    endtask

    task automatic test_mask_and_withdraw();
        write_mask(4'b1110);
        INT_IN = 4'b0001;
        tick(4);
        n_checks++;
        if (PENDING !== 4'b0001 || INTV !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_hold: got pend=%b intv=%b want 0001/0", PENDING, INTV);
        end
        INT_IN = 4'b0000;
        write_mask(4'hF);
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd0) begin
            n_fail++;
            $display("FAIL mask_unmask: got intv=%b id=%0d want 1/0", INTV, INT_ID);
        end
        pulse_clr();
        tick();
        n_checks++;
        if (INTV !== 1'b0 || PENDING !== 4'b0001 || I_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw: got intv=%b pend=%b iflag=%b want 0/0001/0",
                     INTV, PENDING, I_FLAG);
        end
        I_SET = 1'b1;
        I_CLR = 1'b1;
        tick();
        I_SET = 1'b0;
        I_CLR = 1'b0;
        tick();
        n_checks++;
        if (I_FLAG !== 1'b0 || INTV !== 1'b0) begin
            n_fail++;
            $display("FAIL set_clr_same: got iflag=%b intv=%b want 0/0", I_FLAG, INTV);
        end
        pulse_set();
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd0) begin
            n_fail++;
            $display("FAIL rerequest: got intv=%b id=%0d want 1/0", INTV, INT_ID);
        end
        pulse_ack();
        pulse_reti();
        tick();
    endtask

    task automatic test_ack_collision();
        INT_IN = 4'b1000;
        tick(4);
        INT_IN = 4'b0000;
        tick(3);
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd3) begin
            n_fail++;
            $display("FAIL coll_req: got intv=%b id=%0d want 1/3", INTV, INT_ID);
        end
        INT_IN = 4'b1000;
        tick(2);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        n_checks++;
        if (PENDING !== 4'b1000 || INTV !== 1'b0 || I_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_pend: got pend=%b intv=%b iflag=%b want 1000/0/0",
                     PENDING, INTV, I_FLAG);
        end
        pulse_reti();
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd3) begin
            n_fail++;
            $display("FAIL coll_again: got intv=%b id=%0d want 1/3", INTV, INT_ID);
        end
        pulse_ack();
        INT_IN = 4'b0000;
        pulse_reti();
        tick(3);
    endtask

    task automatic test_async_reset();
        INT_IN = 4'b0110;
        tick(4);
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_req: got intv=%b id=%0d want 1/1", INTV, INT_ID);
        end
        pulse_ack();
        n_checks++;
        if (PENDING !== 4'b0100 || I_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_service: got pend=%b iflag=%b want 0100/0",
                     PENDING, I_FLAG);
        end
        INT_IN = 4'b0010;
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if ({INTV, INT_ID, I_FLAG, MASK, PENDING} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 000",
                     {INTV, INT_ID, I_FLAG, MASK, PENDING});
        end
        #2 RESET = 1'b0;
        tick(3);
        n_checks++;
        if (PENDING !== 4'b0010 || INTV !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_edge: got pend=%b intv=%b want 0010/0", PENDING, INTV);
        end
        write_mask(4'hF);
        pulse_set();
        tick();
        n_checks++;
        if (INTV !== 1'b1 || INT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_req2: got intv=%b id=%0d want 1/1", INTV, INT_ID);
        end
        pulse_ack();
        tick(5);
        n_checks++;
        if (PENDING !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_one_edge: got pend=%b want 0000", PENDING);
        end
        pulse_reti();
        tick(2);
        n_checks++;
        if (INTV !== 1'b0 || I_FLAG !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_final: got intv=%b iflag=%b want 0/1", INTV, I_FLAG);
        end
        INT_IN = 4'b0000;
    endtask

    initial begin
        RESET    = 1'b1;
        INT_IN   = 4'b0000;
        I_SET    = 1'b0;
        I_CLR    = 1'b0;
        INT_ACK  = 1'b0;
        RETI     = 1'b0;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        test_reset();
        test_basic();
        test_priority();
        test_mask_and_withdraw();
        test_ack_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_int_ctrl.md
RAT_INT_CTRL -- requirements
Module: rat_int_ctrl

Interface
REQ-001 The block SHALL have the parameter MASK_PORT, default 8'h30, giving the PORT_ID that writes the interrupt mask register.
REQ-002 The block SHALL have the parameter NSRC, default 4, giving the number of interrupt sources (fixed at 4 for this revision).
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high on RESET.
REQ-004 The ports SHALL be as follows:
- clk  in  1  system clock
- RESET  in  1  async active-high reset
- INT_IN  in  4  raw external interrupt lines, asynchronous, rising-edge significant
- I_SET  in  1  control-unit SEI strobe
- I_CLR  in  1  control-unit CLI strobe
- INT_ACK  in  1  control-unit strobe, one cycle, on entering its interrupt cycle
- RETI  in  1  control-unit strobe, one cycle, on executing RETID/RETIE
- IO_STRB  in  1  OUT write strobe
- PORT_ID  in  8  OUT port address
- OUT_PORT  in  8  OUT data
- INTV  out  1  registered interrupt request to the control unit
- INT_ID  out  2  index of the source being requested or serviced
- I_FLAG  out  1  global interrupt enable
- MASK  out  4  current mask register (1 = enabled)
- PENDING  out  4  current pending register

Function
REQ-005 Each INT_IN bit SHALL pass through a 2-flop synchronizer followed by a previous-value register; a rising edge SHALL be detected when sync2=1 and prev=0.
REQ-006 Latency: INT_IN high at clk edge N SHALL give PENDING bit = 1 after edge N+2 and INTV = 1 after edge N+3, provided the request condition in REQ-010 holds.
REQ-007 A detected edge SHALL set its PENDING bit; a level held high SHALL NOT re-set the bit after it has been cleared.
REQ-008 IO_STRB=1 with PORT_ID==MASK_PORT SHALL load MASK with OUT_PORT[3:0] at the next edge. Masking SHALL NOT clear PENDING; a masked pending bit SHALL become eligible when it is unmasked.
REQ-009 I_FLAG SHALL be set by I_SET and cleared by I_CLR. If both are asserted in the same cycle, I_CLR SHALL win.
REQ-010 The request condition SHALL be I_FLAG & |(PENDING & MASK). The highest priority SHALL be the lowest index.
REQ-011 The state machine SHALL have the states IDLE, REQ and SERVICE:
- IDLE -> REQ when the request condition holds; INT_ID latches the winning index and INTV=1 from the next cycle.
- REQ -> IDLE when the request condition drops before INT_ACK (for example I_CLR or a mask change); INTV returns to 0.
- REQ -> SERVICE on INT_ACK; the PENDING bit INT_ID is cleared, I_FLAG is cleared and INTV=0.
- SERVICE -> IDLE on RETI; I_FLAG is set.
REQ-012 INTV SHALL be 1 only in REQ.
REQ-013 INT_ID SHALL be held constant during REQ and SERVICE, even if a higher-priority source becomes pending.
REQ-014 INT_ACK SHALL be ignored in IDLE and SERVICE. RETI SHALL be ignored in IDLE and REQ.
REQ-015 I_SET and I_CLR SHALL be ignored in SERVICE.
REQ-016 If a new edge and an INT_ACK clear hit the same PENDING bit in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-017 Edges on other sources during SERVICE SHALL be recorded in PENDING. They SHALL be requested after RETI, no earlier than 1 cycle after the return to IDLE.
REQ-018 There SHALL be no combinational path from any input to INTV.

Reset
REQ-019 While RESET=1, the block SHALL hold the following values, asynchronously and independent of clk:
- state = IDLE, INTV = 0, INT_ID = 0
- I_FLAG = 0, MASK = 4'h0, PENDING = 4'h0
- all synchronizer and previous-value registers = 0
REQ-020 RESET asserted mid-REQ or mid-SERVICE SHALL abort the service with no residual pending bit.
REQ-021 A source held high across the release of RESET SHALL register as exactly one edge.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Basic request: MASK=4'hF via OUT to 8'h30, I_SET pulse, INT_IN[2] rises at edge N -> PENDING=4'b0100 after N+2, INTV=1 and INT_ID=2 after N+3; INT_ACK -> INTV=0, I_FLAG=0, PENDING=0; RETI -> I_FLAG=1.
- Priority: INT_IN[3] and INT_IN[1] rise together, all enabled -> INT_ID=1. After INT_ACK and RETI -> INT_ID=3 requested, INTV=1.
- Mask: MASK=4'b1110, INT_IN[0] rises -> PENDING[0]=1 and INTV stays 0; write MASK=4'hF -> INTV=1 and INT_ID=0.
- Withdrawal: in REQ, I_CLR pulse -> back to IDLE, INTV=0, PENDING bit retained. I_SET and I_CLR in the same cycle -> I_FLAG=0.
- Ack collision: a new edge on source k in the same cycle as INT_ACK for k -> PENDING[k]=1 after the edge.
- Async reset in SERVICE: pulse RESET between clk edges -> all outputs zero immediately; INT_IN[1] held high through the release of RESET -> exactly one PENDING[1] set.
